serial_adder_ctrl: RTL
======================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled each rising edge.
REQ-005 SHALL have port a, input, WIDTH bits: operand A, sampled only when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits: operand B, sampled only when start is accepted.
REQ-007 SHALL have port cin, input, 1 bit: carry-in, sampled only when start is accepted.
REQ-008 SHALL have port busy, output, 1 bit: high while in state RUN.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-010 SHALL have port sum, output, WIDTH bits: registered result.
REQ-011 SHALL have port cout, output, 1 bit: registered carry-out.

Function
REQ-012 SHALL sequence one 1-bit full-adder cell over WIDTH cycles, LSB first: a bit-serial a+b+cin.
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL accept start only in IDLE or DONE; accepting latches a, b and cin, clears the bit counter and enters RUN.
REQ-015 SHALL, in RUN, process bit i (counter value i) on each edge: carry register <= cell carry; the sum bit is shifted in.
REQ-016 SHALL enter DONE after bit WIDTH-1, making sum and cout valid.
REQ-017 SHALL have latency: start accepted at edge 0, then done=1 during the cycle following edge WIDTH.
REQ-018 SHALL leave DONE after one cycle, going to IDLE, or to RUN if start=1 then (back-to-back; no idle gap).
REQ-019 SHALL ignore start while in RUN, leaving the operands, counter and result unaffected.
REQ-020 SHALL hold sum and cout stable from DONE until the next accepted start.
REQ-021 SHALL leave sum undefined to observers while busy=1; only done qualifies it.
REQ-022 SHALL compute cout as the carry out of bit WIDTH-1, so that {cout,sum} = a+b+cin modulo 2^(WIDTH+1).
REQ-023 SHALL size the bit counter to clog2(WIDTH) bits, with no wrap before WIDTH-1 is reached.

Reset
REQ-024 SHALL, when rst=1 at a rising edge, force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0 and carry=0.
REQ-025 SHALL give rst priority over start on the same edge.
REQ-026 SHALL, on rst mid-RUN, abort the operation with no done pulse; a new start is accepted on the first edge with rst=0.

Configuration
REQ-027 SHALL, with macro SERIAL_ADDER_OVERFLOW_EN defined, add output ovf, 1 bit: two's-complement signed overflow.
REQ-028 SHALL compute ovf as the carry into bit WIDTH-1 XOR the carry out of it, registered with sum and cout.
REQ-029 SHALL apply to ovf the same reset (0) and hold rules as sum and cout.
REQ-030 SHALL, without SERIAL_ADDER_OVERFLOW_EN, have no ovf port and no related logic.

Structure
REQ-031 SHALL take the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default from shared package serial_adder_pkg.
REQ-032 SHALL instantiate exactly one sub-module, full_adder_cell (inputs a, b, cin; outputs sum, carry; combinational), as the datapath.
REQ-033 SHALL keep the FSM, counter and shift registers in serial_adder_ctrl.

Verification
REQ-034 SHALL cover basic add (WIDTH=8): a=0x0F, b=0x01, cin=0 -> done at edge 9, sum=0x10, cout=0, busy high for edges 1..8.
REQ-035 SHALL cover carry out: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; and a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-036 SHALL cover start during RUN: a second start (a=0x55) at edge 3 -> ignored; result is still that of the first operation; exactly one done pulse.
REQ-037 SHALL cover back-to-back: start held high -> done pulses every 9 cycles (WIDTH+1) with correct sums for each operand pair.
REQ-038 SHALL cover reset mid-op: rst at edge 4 -> next cycle busy=0, sum=0, cout=0, no done; a fresh start completes correctly.
REQ-039 SHALL cover overflow (macro defined): a=0x7F, b=0x01 -> sum=0x80, ovf=1; a=0xFF, b=0x01 -> ovf=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Purpose: shared FSM state encoding and default operand width for the serial adder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Purpose: single-bit full adder, the datapath cell stepped by serial_adder_ctrl.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  // Sum and carry of one bit position.
  always_comb begin
    sum   = a ^ b ^ cin;
    carry = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Purpose: bit-serial a+b+cin, LSB first, one full-adder cell reused over WIDTH cycles;
//          optional signed-overflow output ovf when SERIAL_ADDER_OVERFLOW_EN is defined.
// Latency: start accepted at edge 0, done pulses in the cycle after edge WIDTH.
// Backpressure: start is ignored while busy; results hold until the next accepted start.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             w_accept;
  logic             w_last;
  logic             w_busy;
  logic             w_done;
  logic             w_cell_sum;
  logic             w_cell_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             r_ovf;
`endif

  // The one adder cell always sees the current LSBs and the running carry.
  full_adder_cell u_cell (
    .a     (r_a[0]),
    .b     (r_b[0]),
    .cin   (r_carry),
    .sum   (w_cell_sum),
    .carry (w_cell_carry)
  );

  // State register; reset wins over any start on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and status decode; start is only honoured from IDLE or DONE.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last       = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Operand/result shift registers, bit counter and carry chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (w_busy) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_cell_carry;
      // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
      r_sum   <= {w_cell_sum, r_sum[WIDTH-1:1]};
      if (w_last) begin
        r_cout <= w_cell_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        // r_carry is the carry into the MSB while the last bit is being processed.
        r_ovf  <= r_carry ^ w_cell_carry;
`endif
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign busy = w_busy;
  assign done = w_done;
  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign ovf  = r_ovf;
`endif

endmodule
